// File: rtl/prog_timer.sv
// Programmable interval timer with prescaler and periodic / one-shot modes.
// The terminal count, prescale ratio and mode are captured on start, so a
// single instance can serve every wait of varying length in a control path.
// Outputs are all registered: tick is a one-cycle pulse per expiry, busy
// reflects RUN, expired is the sticky one-shot completion flag.
module prog_timer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PS_WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic                start,
  input  logic                mode,
  input  logic [WIDTH-1:0]    load_value,
  input  logic [PS_WIDTH-1:0] prescale,
  output logic [WIDTH-1:0]    count,
  output logic                tick,
  output logic                busy,
  output logic                expired
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StExpired = 2'd2
  } state_e;

  state_e              state_q;
  logic [WIDTH-1:0]    count_q;
  logic [PS_WIDTH-1:0] ps_cnt_q;
  logic [WIDTH-1:0]    term_q;
  logic [PS_WIDTH-1:0] ps_q;
  logic                mode_q;
  logic                tick_q;
  logic                busy_q;
  logic                expired_q;

  // Decoded step conditions, only meaningful in RUN.
  logic step;
  logic at_term;

  // A step happens when the prescaler has reached its latched ratio.
  always_comb begin
    step    = (state_q == StRun) && enable && (ps_cnt_q == ps_q);
    at_term = (count_q == term_q);
  end

  // Timer FSM with registered outputs; clear beats start beats stepping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      ps_cnt_q  <= '0;
      term_q    <= '0;
      ps_q      <= '0;
      mode_q    <= 1'b0;
      tick_q    <= 1'b0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
    end else if (clear) begin
      // Latched configuration is deliberately kept across a clear.
      state_q   <= StIdle;
      count_q   <= '0;
      ps_cnt_q  <= '0;
      tick_q    <= 1'b0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
    end else if (start) begin
      // Also serves as restart when already running.
      term_q    <= load_value;
      ps_q      <= prescale;
      mode_q    <= mode;
      state_q   <= StRun;
      count_q   <= '0;
      ps_cnt_q  <= '0;
      tick_q    <= 1'b0;
      busy_q    <= 1'b1;
      expired_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      unique case (state_q)
        StRun: begin
          if (step) begin
            ps_cnt_q <= '0;
            if (at_term) begin
              tick_q <= 1'b1;
              if (mode_q) begin
                // One-shot: park at the terminal value.
                state_q   <= StExpired;
                busy_q    <= 1'b0;
                expired_q <= 1'b1;
              end else begin
                count_q <= '0;
              end
            end else begin
              count_q <= count_q + 1'b1;
            end
          end else if (enable) begin
            ps_cnt_q <= ps_cnt_q + 1'b1;
          end
        end
        StIdle: begin
          count_q  <= '0;
          ps_cnt_q <= '0;
        end
        StExpired: begin
          count_q <= term_q;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign count   = count_q;
  assign tick    = tick_q;
  assign busy    = busy_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_prog_timer.sv
// Scoreboard bench for prog_timer: stimulus pushes expected ticks (cycle,
// count, busy) into a queue and a monitor pops one on every observed tick.
module tb_prog_timer;

  localparam int W  = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          clear;
  logic          start;
  logic          mode;
  logic [W-1:0]  load_value;
  logic [PW-1:0] prescale;
  logic [W-1:0]  count;
  logic          tick;
  logic          busy;
  logic          expired;

  prog_timer #(
    .WIDTH   (W),
    .PS_WIDTH(PW)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .clear     (clear),
    .start     (start),
    .mode      (mode),
    .load_value(load_value),
    .prescale  (prescale),
    .count     (count),
    .tick      (tick),
    .busy      (busy),
    .expired   (expired)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; stable when sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int cnt;
    int bsy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_tick(input int c, input int cnt, input int bsy);
    exp_t e;
    e.cyc = c;
    e.cnt = cnt;
    e.bsy = bsy;
    sb.push_back(e);
  endtask

  // Monitor: every tick must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && tick === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_tick: got tick at cycle %0d expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("tick_cycle", cyc, mon_e.cyc);
        check("tick_count", {24'd0, count}, mon_e.cnt);
        check("tick_busy", {31'd0, busy}, mon_e.bsy);
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called on a falling edge; returns with cyc equal to the start edge index.
  task automatic do_start(input logic m, input int n, input int p, output int s);
    start      = 1'b1;
    mode       = m;
    load_value = W'(n);
    prescale   = PW'(p);
    s          = cyc + 1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  int s;

  initial begin
    reset      = 1'b0;
    enable     = 1'b1;
    clear      = 1'b0;
    start      = 1'b0;
    mode       = 1'b0;
    load_value = '0;
    prescale   = '0;
    repeat (3) @(negedge clk);
    check("rst_count", {24'd0, count}, 0);
    check("rst_tick", {31'd0, tick}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_expired", {31'd0, expired}, 0);
    reset = 1'b1;
    @(negedge clk);

    // Periodic, N=5, P=0: ticks 6, 12, 18 edges after start.
    do_start(1'b0, 5, 0, s);
    push_tick(s + 6, 0, 1);
    push_tick(s + 12, 0, 1);
    push_tick(s + 18, 0, 1);
    for (int k = 0; k <= 6; k++) begin
      wait_cyc(s + k);
      check("per_count", {24'd0, count}, k % 6);
      check("per_busy", {31'd0, busy}, 1);
    end
    wait_cyc(s + 20);
    do_clear();
    check("clr_busy", {31'd0, busy}, 0);

    // One-shot, N=3, P=2: single tick 12 edges after start.
    do_start(1'b1, 3, 2, s);
    push_tick(s + 12, 3, 0);
    wait_cyc(s + 2);
    check("os_count_hold", {24'd0, count}, 0);
    wait_cyc(s + 3);
    check("os_count_step", {24'd0, count}, 1);
    load_value = 8'd200;
    prescale   = 4'd0;
    mode       = 1'b0;
    wait_cyc(s + 11);
    check("os_count_pre", {24'd0, count}, 3);
    check("os_busy_pre", {31'd0, busy}, 1);
    wait_cyc(s + 13);
    check("os_expired", {31'd0, expired}, 1);
    check("os_busy", {31'd0, busy}, 0);
    check("os_count_term", {24'd0, count}, 3);
    wait_cyc(s + 63);
    check("os_expired_sticky", {31'd0, expired}, 1);
    check("os_count_sticky", {24'd0, count}, 3);
    do_clear();
    check("os_clr_expired", {31'd0, expired}, 0);
    check("os_clr_count", {24'd0, count}, 0);

    // Enable gating: N=4, P=0, freeze 7 edges at count 2 -> tick at +12.
    do_start(1'b0, 4, 0, s);
    push_tick(s + 12, 0, 1);
    wait_cyc(s + 2);
    enable = 1'b0;
    wait_cyc(s + 9);
    check("gate_frozen", {24'd0, count}, 2);
    check("gate_busy", {31'd0, busy}, 1);
    enable = 1'b1;
    wait_cyc(s + 11);
    check("gate_resume", {24'd0, count}, 4);
    wait_cyc(s + 14);
    do_clear();

    // Clear and start together: clear wins.
    do_start(1'b0, 10, 0, s);
    wait_cyc(s + 3);
    check("cs_count_pre", {24'd0, count}, 3);
    clear      = 1'b1;
    start      = 1'b1;
    load_value = 8'd1;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    check("cs_busy", {31'd0, busy}, 0);
    check("cs_count", {24'd0, count}, 0);
    // Max terminal and prescale: 256*16 = 4096 edges.
    do_start(1'b0, 255, 15, s);
    push_tick(s + 4096, 0, 1);
    load_value = 8'd1;
    prescale   = 4'd0;
    wait_cyc(s + 16);
    check("max_count_step", {24'd0, count}, 1);
    wait_cyc(s + 4095);
    check("max_count_term", {24'd0, count}, 255);
    wait_cyc(s + 4097);
    check("max_count_wrap", {24'd0, count}, 0);
    do_clear();

    // Zero terminal, P=1: tick every second edge, count stays 0.
    do_start(1'b0, 0, 1, s);
    push_tick(s + 2, 0, 1);
    push_tick(s + 4, 0, 1);
    push_tick(s + 6, 0, 1);
    push_tick(s + 8, 0, 1);
    wait_cyc(s + 3);
    check("zero_count", {24'd0, count}, 0);
    wait_cyc(s + 9);
    do_clear();

    // Asynchronous reset mid-run at count 7.
    do_start(1'b0, 20, 0, s);
    wait_cyc(s + 7);
    check("ar_count_pre", {24'd0, count}, 7);
    #2;
    reset = 1'b0;
    #1;
    check("ar_count", {24'd0, count}, 0);
    check("ar_busy", {31'd0, busy}, 0);
    check("ar_tick", {31'd0, tick}, 0);
    check("ar_expired", {31'd0, expired}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    check("ar_idle_busy", {31'd0, busy}, 0);
    check("ar_idle_count", {24'd0, count}, 0);

    check("missed_ticks", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prog_timer.md
Name: prog_timer

Overview:
- Programmable, parameter-width interval timer with a clock prescaler and periodic or one-shot modes.
- The terminal count, prescale ratio and mode are latched at start, so one instance serves every wait in the multiplier control path without re-synthesis.
- It produces a one-cycle registered tick at each expiry, a sticky expired flag in one-shot mode, and a live count output.

Parameters:
- WIDTH, 8, width of main counter and terminal value.
- PS_WIDTH, 4, width of prescale ratio field.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- enable  input  1  count-advance qualifier; low freezes both counters and state
- clear  input  1  synchronous abort; returns block to IDLE
- start  input  1  synchronous launch; latches load_value, prescale, mode
- mode  input  1  0 = periodic, 1 = one-shot
- load_value  input  WIDTH  terminal count N (period N+1 steps)
- prescale  input  PS_WIDTH  prescale ratio P (one step every P+1 enabled cycles)
- count  output  WIDTH  current main count
- tick  output  1  registered one-cycle pulse per expiry
- busy  output  1  high in RUN
- expired  output  1  sticky one-shot completion flag

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; count, prescaler, term_reg, ps_reg, mode_reg = 0.
  - tick, busy, expired = 0.
- Priority each edge: reset > clear > start > enable-gated step.
- States:
  - IDLE: counters hold 0; busy=0.
  - RUN: busy=1.
  - EXPIRED (one-shot only): busy=0, expired=1, count holds term_reg.
- clear (any state): next state IDLE; count=0; prescaler=0; tick=0; expired=0. Latched registers unchanged.
- start (any state, clear low):
  - term_reg<=load_value, ps_reg<=prescale, mode_reg<=mode.
  - count<=0, prescaler<=0, expired<=0, tick<=0, state<=RUN.
  - A start during RUN restarts the timer.
- Step (RUN only): occurs on an edge where enable=1 and prescaler==ps_reg.
  - On a step, prescaler<=0.
  - On an enabled non-step edge, prescaler<=prescaler+1.
  - enable=0: prescaler, count and state hold; tick<=0.
- On a step with count!=term_reg: count<=count+1, tick<=0.
- On a step with count==term_reg: tick<=1 for exactly one cycle.
  - Periodic: count<=0, remain RUN.
  - One-shot: count holds term_reg, state<=EXPIRED, expired<=1.
- tick is 0 on every edge that is not an expiring step. tick never stays high two consecutive cycles, except when term_reg=0 and ps_reg=0 in periodic mode, where it is continuously high while enabled.
- Period in periodic mode: (term_reg+1)*(ps_reg+1) enabled cycles.
- First tick: visible in the cycle after the ((term_reg+1)*(ps_reg+1))th enabled edge following the start edge.
- load_value=0 gives one tick per step.
- Maximum values (all-ones load_value/prescale): no overflow. count and prescaler never exceed their latched terminal values and wrap only via the terminal compare.
- Inputs load_value/prescale/mode are ignored except on start edges; changing them mid-run has no effect.
- enable has no effect in IDLE or EXPIRED.
- Asynchronous reset mid-RUN aborts immediately to the reset values above.

Test Plan:
- Periodic, P=0: reset, start with mode=0, load_value=5, prescale=0, enable=1 held → tick high the cycle after edges 6, 12, 18 from start; count sequence 0,1,2,3,4,5,0; busy=1 throughout.
- Prescaled one-shot: start with mode=1, load_value=3, prescale=2 → count steps every 3 cycles; single tick after edge 12; then expired=1, busy=0, count=3, with no further ticks over 50 cycles.
- Enable gating: periodic, load_value=4, P=0; drop enable for 7 cycles at count=2 → count and prescaler frozen at 2; tick arrives 7 cycles later than the ungated case.
- Clear vs start priority: in RUN at count=3, assert clear and start together → IDLE, count=0, busy=0. Next cycle start alone with load_value=255, prescale=15 → tick after 4096 enabled edges; no overflow.
- Zero terminal: start periodic with load_value=0, prescale=1 → tick every 2nd cycle; count stays 0.
- Reset mid-operation: assert reset asynchronously between clock edges in RUN at count=7 → all outputs 0 immediately. After release, no ticks until a new start.
